instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch_pkg.sv | 18 +
 rtl/instr_prefetch_fifo.sv | 81 ++++++++
 rtl/instr_prefetch.sv | 144 ++++++++++++++
 tb/tb_instr_prefetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetcher: FSM state encoding,
// FIFO entry layout and the sequential fetch stride.
package instr_prefetch_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // nothing outstanding
        ST_WAIT    = 2'd1,  // one valid read outstanding
        ST_DISCARD = 2'd2   // one stale read outstanding, response is dropped
    } ipf_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ipf_entry_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// ipf_fifo: DEPTH x {addr, data} prefetch buffer with push, pop and flush.
// Flush wins over push/pop; simultaneous push and pop keep the count.
module ipf_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  ipf_entry_t push_entry_i,
    output ipf_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    ipf_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointer and occupancy next-state; pointers wrap explicitly for non power-of-two depths.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) begin
                wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[wptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential instruction prefetcher with a small FIFO,
// one outstanding memory read, combinational hit grant and PC redirect.
// Optional feature: define IPF_BYPASS_EN to grant a response directly
// from memory when the FIFO is empty and the response matches i_PC.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic [31:0] i_PC,
    input  logic        i_INSTR_REQ,
    output logic [31:0] o_INSTRUCTION,
    output logic        o_INSTR_GNT,
    output logic [31:0] o_MEM_ADDR,
    output logic        o_MEM_RE,
    input  logic [31:0] i_MEM_RDATA,
    input  logic        i_MEM_VALID
);

    ipf_state_e  state_q, state_d;
    logic [31:0] fptr_q, fptr_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_re_q, mem_re_d;

    ipf_entry_t  fifo_head;
    ipf_entry_t  push_entry;
    logic        fifo_full, fifo_empty;
    logic        push, pop, flush;

    logic [31:0] exp_pc;
    logic        redirect;
    logic        hit_gnt;
    logic        bypass_gnt;

    ipf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (i_CLK),
        .rst_ni       (i_RSTn),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (flush),
        .push_entry_i (push_entry),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // Expected PC, redirect detection and grant generation.
    always_comb begin
        if (!fifo_empty) begin
            exp_pc = fifo_head.addr;
        end else if (state_q == ST_WAIT) begin
            exp_pc = out_addr_q;
        end else begin
            exp_pc = fptr_q;
        end
        redirect = i_INSTR_REQ && (exp_pc != i_PC);
        hit_gnt  = i_INSTR_REQ && !fifo_empty && (fifo_head.addr == i_PC);
`ifdef IPF_BYPASS_EN
        bypass_gnt = (state_q == ST_WAIT) && fifo_empty && i_MEM_VALID
                     && i_INSTR_REQ && (out_addr_q == i_PC);
`else
        bypass_gnt = 1'b0;
`endif
    end

    assign pop         = hit_gnt;
    assign flush       = redirect;
    assign push_entry  = '{addr: out_addr_q, data: i_MEM_RDATA};
    assign o_INSTR_GNT = hit_gnt | bypass_gnt;
`ifdef IPF_BYPASS_EN
    assign o_INSTRUCTION = bypass_gnt ? i_MEM_RDATA : fifo_head.data;
`else
    assign o_INSTRUCTION = fifo_head.data;
`endif
    assign o_MEM_ADDR  = mem_addr_q;
    assign o_MEM_RE    = mem_re_q;

    // FSM next-state: issue a strobe from IDLE, capture or drop the response.
    always_comb begin
        state_d    = state_q;
        fptr_d     = fptr_q;
        out_addr_d = out_addr_q;
        mem_addr_d = mem_addr_q;
        mem_re_d   = 1'b0;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fptr_d = i_PC;
                end else if (!fifo_full) begin
                    mem_re_d   = 1'b1;
                    mem_addr_d = fptr_q;
                    out_addr_d = fptr_q;
                    fptr_d     = fptr_q + PC_STEP;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    fptr_d  = i_PC;
                    // A response landing with the redirect is dropped here,
                    // so nothing is left outstanding to discard later.
                    state_d = i_MEM_VALID ? ST_IDLE : ST_DISCARD;
                end else if (i_MEM_VALID) begin
                    push    = !bypass_gnt;
                    state_d = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    fptr_d = i_PC;
                end
                if (i_MEM_VALID) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and memory-interface registers.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q    <= ST_IDLE;
            fptr_q     <= BOOT_ADDR;
            out_addr_q <= BOOT_ADDR;
            mem_addr_q <= BOOT_ADDR;
            mem_re_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fptr_q     <= fptr_d;
            out_addr_q <= out_addr_d;
            mem_addr_q <= mem_addr_d;
            mem_re_q   <= mem_re_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: reset, fetch latency, streaming,
// redirect/discard, address wrap, reset during a read, optional bypass.
module tb_instr_prefetch;
    import instr_prefetch_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        req;
    logic [31:0] instr;
    logic        gnt;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    logic        auto_mem;
    logic        pend_v;
    logic [31:0] pend_a;

    int unsigned passed;
    int unsigned failed;
    int unsigned total;

    instr_prefetch #(
        .BOOT_ADDR (32'h0000_0000),
        .DEPTH     (DEPTH)
    ) dut (
        .i_CLK         (clk),
        .i_RSTn        (rst_n),
        .i_PC          (pc),
        .i_INSTR_REQ   (req),
        .o_INSTRUCTION (instr),
        .o_INSTR_GNT   (gnt),
        .o_MEM_ADDR    (mem_addr),
        .o_MEM_RE      (mem_re),
        .i_MEM_RDATA   (mem_rdata),
        .i_MEM_VALID   (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; the memory model answers one cycle after a strobe
    // with data = addr ^ 32'hDEAD_0000 when auto_mem is set.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            mem_valid = pend_v;
            mem_rdata = pend_v ? (pend_a ^ 32'hDEAD_0000) : 32'h0;
        end else begin
            mem_valid = 1'b0;
            mem_rdata = 32'h0;
        end
        pend_v = mem_re;
        pend_a = mem_addr;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 1'b0;
        pc        = 32'h0;
        mem_valid = 1'b0;
        mem_rdata = 32'h0;
        pend_v    = 1'b0;
        pend_a    = 32'h0;
        #1;
        check("rst_re", 32'(mem_re), 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        passed   = 0;
        failed   = 0;
        total    = 0;
        auto_mem = 1'b1;

        // ---- reset state, with a request pending ----
        do_reset();
        rst_n = 1'b0;
        req   = 1'b1;
        pc    = 32'h0;
        settle();
        check("rst_gnt_req", 32'(gnt), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst_n = 1'b1;

        // ---- first fetches after reset, latency 1, PC held at 0 ----
        tick();
        check("boot_re0", 32'(mem_re), 32'h1);
        check("boot_addr0", mem_addr, 32'h0);
        check("boot_gnt_c1", 32'(gnt), 32'h0);
        tick();
        check("boot_gnt_c2", 32'(gnt), 32'h0);
        check("boot_re_c2", 32'(mem_re), 32'h0);
        tick();
        check("boot_gnt0", 32'(gnt), 32'h1);
        check("boot_instr0", instr, 32'hDEAD_0000);
        tick();
        check("boot_re1", 32'(mem_re), 32'h1);
        check("boot_addr1", mem_addr, 32'h4);
        pc = 32'h4;
        settle();
        check("boot_gnt_c4", 32'(gnt), 32'h0);
        tick();
        tick();
        check("boot_gnt1", 32'(gnt), 32'h1);
        check("boot_instr1", instr, 32'hDEAD_0004);

        // ---- streaming from a primed FIFO ----
        do_reset();
        auto_mem = 1'b1;
        req = 1'b1;
        pc  = 32'h100;
        settle();
        check("str_redirect_gnt", 32'(gnt), 32'h0);
        tick();
        req = 1'b0;
        repeat (10) tick();
        check("str_primed_cnt", 32'(dut.u_fifo.cnt_q), 32'(DEPTH));
        check("str_full_no_re", 32'(mem_re), 32'h0);
        req = 1'b1;
        pc  = 32'h100;
        settle();
        check("str_gnt100", 32'(gnt), 32'h1);
        check("str_instr100", instr, 32'hDEAD_0100);
        tick();
        pc = 32'h104;
        settle();
        check("str_gnt104", 32'(gnt), 32'h1);
        check("str_instr104", instr, 32'hDEAD_0104);
        check("str_cnt1", 32'(dut.u_fifo.cnt_q), 32'h1);
        tick();
        pc = 32'h108;
        settle();
        check("str_re108", 32'(mem_re), 32'h1);
        check("str_addr108", mem_addr, 32'h108);
        check("str_gnt_empty", 32'(gnt), 32'h0);
        tick();
        check("str_gnt_resp", 32'(gnt), 32'h0);
        check("str_cnt_le", 32'(dut.u_fifo.cnt_q <= DEPTH), 32'h1);
        tick();
        check("str_gnt108", 32'(gnt), 32'h1);
        check("str_instr108", instr, 32'hDEAD_0108);

        // ---- redirect while a read is outstanding ----
        do_reset();
        auto_mem = 1'b0;
        req = 1'b1;
        pc  = 32'h10;
        tick();
        tick();
        check("rd_re10", 32'(mem_re), 32'h1);
        check("rd_addr10", mem_addr, 32'h10);
        pc = 32'h200;
        settle();
        check("rd_gnt_redirect", 32'(gnt), 32'h0);
        tick();
        check("rd_state_discard", 32'(dut.state_q), 32'(ST_DISCARD));
        check("rd_no_re", 32'(mem_re), 32'h0);
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_0010;
        settle();
        check("rd_stale_gnt", 32'(gnt), 32'h0);
        tick();
        check("rd_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("rd_cnt0", 32'(dut.u_fifo.cnt_q), 32'h0);
        check("rd_gnt_after", 32'(gnt), 32'h0);
        tick();
        check("rd_re200", 32'(mem_re), 32'h1);
        check("rd_addr200", mem_addr, 32'h200);

        // ---- fetch pointer wrap ----
        do_reset();
        auto_mem = 1'b1;
        req = 1'b1;
        pc  = 32'hFFFF_FFFC;
        tick();
        tick();
        check("wrap_re_top", 32'(mem_re), 32'h1);
        check("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
        req = 1'b0;
        tick();
        tick();
        tick();
        check("wrap_re0", 32'(mem_re), 32'h1);
        check("wrap_addr0", mem_addr, 32'h0);
        req = 1'b1;
        pc  = 32'hFFFF_FFFC;
        settle();
        check("wrap_gnt", 32'(gnt), 32'h1);
        check("wrap_instr", instr, 32'h2152_FFFC);

        // ---- reset during an outstanding read, late response ignored ----
        do_reset();
        auto_mem = 1'b0;
        tick();
        check("rw_re", 32'(mem_re), 32'h1);
        check("rw_state_wait", 32'(dut.state_q), 32'(ST_WAIT));
        rst_n = 1'b0;
        settle();
        check("rw_rst_re", 32'(mem_re), 32'h0);
        check("rw_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        tick();
        rst_n     = 1'b1;
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_0000;
        req       = 1'b1;
        pc        = 32'h0;
        settle();
        check("rw_late_gnt", 32'(gnt), 32'h0);
        tick();
        check("rw_no_push", 32'(dut.u_fifo.cnt_q), 32'h0);
        check("rw_reissue_re", 32'(mem_re), 32'h1);
        check("rw_reissue_addr", mem_addr, 32'h0);
        check("rw_gnt_after", 32'(gnt), 32'h0);

        // ---- response for the requested PC with an empty FIFO ----
        do_reset();
        auto_mem = 1'b0;
        req = 1'b1;
        pc  = 32'h40;
        tick();
        tick();
        check("bp_re40", 32'(mem_re), 32'h1);
        check("bp_addr40", mem_addr, 32'h40);
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'h0000_0013;
        settle();
`ifdef IPF_BYPASS_EN
        check("bp_same_gnt", 32'(gnt), 32'h1);
        check("bp_same_instr", instr, 32'h0000_0013);
        tick();
        pc = 32'h44;
        settle();
        check("bp_next_gnt", 32'(gnt), 32'h0);
        check("bp_no_push", 32'(dut.u_fifo.cnt_q), 32'h0);
`else
        check("bp_same_gnt", 32'(gnt), 32'h0);
        tick();
        check("bp_next_gnt", 32'(gnt), 32'h1);
        check("bp_next_instr", instr, 32'h0000_0013);
        check("bp_pushed", 32'(dut.u_fifo.cnt_q), 32'h1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
